// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency word reads, buffers returns in a FIFO.
// Optional decode-starvation counter enabled by defining FETCH_PERF_COUNT_EN.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic [31:0] Imem_Data,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    input  logic        Stall,
    output logic        Instr_Valid,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlusFour,
    output logic [31:0] Fetch_PC,
    output logic [31:0] Bubble_Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      infl_addr_q, infl_addr_d;
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      data_mem_d [DEPTH];
    logic [31:0]      addr_mem_q [DEPTH];
    logic [31:0]      addr_mem_d [DEPTH];

    logic             instr_valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] credit_limit;

    always_comb begin
        instr_valid  = (count_q != '0);
        pop          = instr_valid && !Stall;
        occupancy    = OCC_W'(count_q) + OCC_W'(inflight_q);
        // A same-cycle pop frees a slot, so a full queue can issue while draining.
        credit_limit = OCC_W'(DEPTH) + OCC_W'(pop);
        issue        = Reset_n && !Redirect && (occupancy < credit_limit);
        // The response landing during a redirect cycle is the killed one; it is never written.
        push         = inflight_q && !Redirect;

        pc_d        = pc_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = 1'b0;
        infl_addr_d = infl_addr_q;
        data_mem_d  = data_mem_q;
        addr_mem_d  = addr_mem_q;

        if (Redirect) begin
            pc_d     = Redirect_PC & ~32'h3;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d        = pc_q + 32'd4;
                infl_addr_d = pc_q;
                inflight_d  = 1'b1;
            end
            if (push) begin
                data_mem_d[wr_ptr_q] = Imem_Data;
                addr_mem_d[wr_ptr_q] = infl_addr_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q        <= RESET_PC;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
        end
    end

    always_ff @(posedge Clock) begin
        data_mem_q <= data_mem_d;
        addr_mem_q <= addr_mem_d;
    end

    assign Imem_Req    = issue;
    assign Imem_Addr   = pc_q;
    assign Instr_Valid = instr_valid;
    assign Instruction = instr_valid ? data_mem_q[rd_ptr_q] : '0;
    assign Fetch_PC    = instr_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign PCPlusFour  = instr_valid ? (addr_mem_q[rd_ptr_q] + 32'd4) : '0;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (!instr_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign Bubble_Count = bubble_q;
`else
    assign Bubble_Count = '0;
`endif

    count_bound_a : assert property (@(posedge Clock) disable iff (!Reset_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a queue-based model of fetch, fill and delivery.
module tb_fetch_prefetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Data;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Stall;
    logic        Instr_Valid;
    logic [31:0] Instruction;
    logic [31:0] PCPlusFour;
    logic [31:0] Fetch_PC;
    logic [31:0] Bubble_Count;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Imem_Req     (Imem_Req),
        .Imem_Addr    (Imem_Addr),
        .Imem_Data    (Imem_Data),
        .Redirect     (Redirect),
        .Redirect_PC  (Redirect_PC),
        .Stall        (Stall),
        .Instr_Valid  (Instr_Valid),
        .Instruction  (Instruction),
        .PCPlusFour   (PCPlusFour),
        .Fetch_PC     (Fetch_PC),
        .Bubble_Count (Bubble_Count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t      fifo [$];
    logic [31:0] m_pc;
    bit          m_pending;
    logic [31:0] m_pending_addr;
    logic [31:0] m_bubbles;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        m_pc           = 32'h0;
        m_pending      = 1'b0;
        m_pending_addr = 32'h0;
        m_bubbles      = 32'h0;
    endtask

    // One clock cycle: drive at negedge, compare 1ns later, advance the model at posedge.
    task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
        bit          e_valid;
        bit          e_pop;
        bit          e_req;
        int          outstanding;
        logic [31:0] data_now;
        entry_t      head;
        Stall       = stall;
        Redirect    = redir;
        Redirect_PC = rpc;
        data_now    = $urandom;
        Imem_Data   = data_now;
        #1;
        e_valid     = (fifo.size() != 0);
        e_pop       = e_valid && !stall;
        outstanding = fifo.size() + (m_pending ? 1 : 0) - (e_pop ? 1 : 0);
        e_req       = !redir && (outstanding < int'(DEPTH));
        check("imem_req", {31'b0, Imem_Req}, {31'b0, e_req});
        if (e_req) check("imem_addr", Imem_Addr, m_pc);
        check("instr_valid", {31'b0, Instr_Valid}, {31'b0, e_valid});
        if (e_valid) begin
            head = fifo[0];
            check("instruction", Instruction, head.data);
            check("fetch_pc", Fetch_PC, head.addr);
            check("pc_plus_four", PCPlusFour, head.addr + 32'd4);
        end else begin
            check("instruction_empty", Instruction, 32'h0);
            check("fetch_pc_empty", Fetch_PC, 32'h0);
            check("pc_plus_four_empty", PCPlusFour, 32'h0);
        end
        check("bubble_count", Bubble_Count, m_bubbles);
        @(posedge Clock);
`ifdef FETCH_PERF_COUNT_EN
        if (!e_valid && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 32'd1;
`endif
        if (redir) begin
            fifo.delete();
            m_pending = 1'b0;
            m_pc      = {rpc[31:2], 2'b00};
        end else begin
            if (e_pop) void'(fifo.pop_front());
            if (m_pending) fifo.push_back('{addr: m_pending_addr, data: data_now});
            m_pending = e_req;
            if (e_req) begin
                m_pending_addr = m_pc;
                m_pc           = m_pc + 32'd4;
            end
        end
        @(negedge Clock);
    endtask

    task automatic reset_pulse();
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_imem_req", {31'b0, Imem_Req}, 32'h0);
        check("rst_instr_valid", {31'b0, Instr_Valid}, 32'h0);
        check("rst_instruction", Instruction, 32'h0);
        check("rst_fetch_pc", Fetch_PC, 32'h0);
        check("rst_pc_plus_four", PCPlusFour, 32'h0);
        check("rst_bubble_count", Bubble_Count, 32'h0);
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n     = 1'b0;
        Stall       = 1'b0;
        Redirect    = 1'b0;
        Redirect_PC = 32'h0;
        Imem_Data   = 32'h0;
        model_reset();
        @(negedge Clock);
        reset_pulse();

        repeat (8) step(1'b0, 1'b0, $urandom);

        reset_pulse();
        repeat (4) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 32'h0000_0100);
        repeat (6) step(1'b0, 1'b0, $urandom);

        repeat (10) step(1'b1, 1'b0, $urandom);
        repeat (10) step(1'b0, 1'b0, $urandom);

        step(1'b0, 1'b1, 32'h0000_0103);
        repeat (5) step(1'b0, 1'b0, $urandom);
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b0, 1'b0, $urandom);

        for (int i = 0; i < 100; i++) step(i[0], 1'b0, $urandom);

        for (int i = 0; i < 300; i++)
            step(($urandom % 3) == 0, ($urandom % 16) == 0, $urandom);

        reset_pulse();
        for (int i = 0; i < 150; i++)
            step(($urandom % 2) == 0, ($urandom % 20) == 0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
